frame_buf_multi: RTL and testbench

Parametrised N-buffer frame store (ping-pong for 2 buffers, triple/quad buffering for 4). A pixel writer fills one frame buffer while a reader scans the most recently completed frame from another. Buffers are never read and written at the same time. It sits between the pixel source and the display/readout path and generalises the single-buffer fill/idle frame buffer. Storage is one data_mem instance of (1<<BUF_BITS)*(1<<ADDR_WIDTH) words, addressed {buf, addr}.

---
 rtl/frame_buf_multi.sv | 161 ++++++++++++++++
 tb/tb_frame_buf_multi.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_multi.sv
// N-buffer frame store: a writer fills one buffer while a reader scans the latest committed one.
// Optional define FRAME_BUF_REPEAT_EN: a read strobe with no new frame rescans the latest frame.
module frame_buf_multi #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 3,
  parameter int BUF_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr_rdy,
  input  logic                  rd_en_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  frame_rdy,
  output logic                  frame_skip,
  output logic [BUF_BITS-1:0]   wr_buf,
  output logic [BUF_BITS-1:0]   rd_buf
);
  localparam int unsigned NUM_BUFS = 1 << BUF_BITS;
  localparam int unsigned DEPTH    = NUM_BUFS << ADDR_WIDTH;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} wr_state_t;
  typedef enum logic       {R_IDLE, R_SCAN} rd_state_t;

  wr_state_t wr_state, wr_state_n;
  rd_state_t rd_state, rd_state_n;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_n, rd_addr, rd_addr_n;
  logic [BUF_BITS-1:0]   wr_buf_n, rd_buf_n, rd_buf_next, latest, free_buf;
  logic                  have_frame, repeat_ok, free_found;
  logic                  wr_accept, commit, rd_start, rd_step, rd_fire, rd_done, rd_busy_next;
  logic [BUF_BITS+ADDR_WIDTH-1:0] raddr;

`ifdef FRAME_BUF_REPEAT_EN
  assign repeat_ok = have_frame;
`else
  assign repeat_ok = 1'b0;
`endif

  assign wr_rdy    = (wr_state != W_WAIT);
  assign wr_accept = wr_en_in & wr_rdy;
  assign commit    = wr_accept && (wr_addr == '1);

  assign rd_start     = (rd_state == R_IDLE) && rd_en_in && (frame_rdy || repeat_ok);
  assign rd_step      = (rd_state == R_SCAN) && rd_en_in;
  assign rd_fire      = rd_start | rd_step;
  assign rd_done      = rd_step && (rd_addr == '1);
  assign rd_busy_next = rd_start || ((rd_state == R_SCAN) && !rd_done);
  assign rd_buf_next  = rd_start ? latest : rd_buf;
  assign raddr        = rd_start ? {latest, {ADDR_WIDTH{1'b0}}} : {rd_buf, rd_addr};

  // First buffer after wr_buf (circularly) the reader will not occupy next cycle;
  // wr_buf itself is never a candidate since it becomes (or already is) latest.
  always_comb begin
    free_found = 1'b0;
    free_buf   = wr_buf;
    for (int unsigned i = 1; i < NUM_BUFS; i++) begin
      if (!free_found && !(rd_busy_next && (wr_buf + BUF_BITS'(i)) == rd_buf_next)) begin
        free_found = 1'b1;
        free_buf   = wr_buf + BUF_BITS'(i);
      end
    end
  end

  always_comb begin
    wr_state_n = wr_state;
    wr_buf_n   = wr_buf;
    wr_addr_n  = wr_addr;
    case (wr_state)
      W_IDLE, W_FILL: begin
        if (wr_accept) begin
          if (commit) begin
            wr_addr_n = '0;
            if (free_found) begin
              wr_buf_n   = free_buf;
              wr_state_n = W_IDLE;
            end else begin
              wr_state_n = W_WAIT;
            end
          end else begin
            wr_addr_n  = wr_addr + 1'b1;
            wr_state_n = W_FILL;
          end
        end
      end
      W_WAIT: begin
        if (free_found) begin
          wr_buf_n   = free_buf;
          wr_state_n = W_IDLE;
        end
      end
      default: wr_state_n = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_n = rd_state;
    rd_buf_n   = rd_buf;
    rd_addr_n  = rd_addr;
    case (rd_state)
      R_IDLE: begin
        if (rd_start) begin
          rd_buf_n   = latest;
          rd_addr_n  = ADDR_WIDTH'(1);
          rd_state_n = R_SCAN;
        end
      end
      R_SCAN: begin
        if (rd_done) begin
          rd_addr_n  = '0;
          rd_state_n = R_IDLE;
        end else if (rd_step) begin
          rd_addr_n = rd_addr + 1'b1;
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state   <= W_IDLE;
      rd_state   <= R_IDLE;
      wr_buf     <= '0;
      rd_buf     <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      latest     <= '0;
      have_frame <= 1'b0;
      frame_rdy  <= 1'b0;
      frame_skip <= 1'b0;
      rd_valid   <= 1'b0;
      data_out   <= '0;
    end else begin
      wr_state   <= wr_state_n;
      rd_state   <= rd_state_n;
      wr_buf     <= wr_buf_n;
      rd_buf     <= rd_buf_n;
      wr_addr    <= wr_addr_n;
      rd_addr    <= rd_addr_n;
      frame_skip <= commit & frame_rdy;
      rd_valid   <= rd_fire;
      if (commit) begin
        latest     <= wr_buf;
        have_frame <= 1'b1;
        frame_rdy  <= 1'b1;
      end else if (rd_start) begin
        frame_rdy <= 1'b0;
      end
      if (rd_fire) data_out <= data_mem[raddr];
    end
  end

  // Storage is not cleared by reset, but a write strobe during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) data_mem[{wr_buf, wr_addr}] <= data_in;
  end
endmodule

// File: tb/tb_frame_buf_multi.sv
// Directed bench for frame_buf_multi: two-buffer instance plus a four-buffer instance.
module tb_frame_buf_multi;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        wr_en, rd_en, wr_rdy, rd_valid, frame_rdy, frame_skip;
  logic [23:0] din, data_out;
  logic [0:0]  wr_buf, rd_buf;

  logic        wr_en4, rd_en4, wr_rdy4, rd_valid4, frame_rdy4, frame_skip4;
  logic [23:0] din4, data_out4;
  logic [1:0]  wr_buf4, rd_buf4;

  int total = 0;
  int bad   = 0;

  frame_buf_multi #(.DATA_WIDTH(24), .ADDR_WIDTH(3), .BUF_BITS(1)) dut (
    .clk(clk), .reset(reset), .wr_en_in(wr_en), .data_in(din), .wr_rdy(wr_rdy),
    .rd_en_in(rd_en), .data_out(data_out), .rd_valid(rd_valid), .frame_rdy(frame_rdy),
    .frame_skip(frame_skip), .wr_buf(wr_buf), .rd_buf(rd_buf)
  );

  frame_buf_multi #(.DATA_WIDTH(24), .ADDR_WIDTH(3), .BUF_BITS(2)) dut4 (
    .clk(clk), .reset(reset), .wr_en_in(wr_en4), .data_in(din4), .wr_rdy(wr_rdy4),
    .rd_en_in(rd_en4), .data_out(data_out4), .rd_valid(rd_valid4), .frame_rdy(frame_rdy4),
    .frame_skip(frame_skip4), .wr_buf(wr_buf4), .rd_buf(rd_buf4)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic [23:0] base);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      din   = base + 24'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic read_frame(input string tag, input logic [23:0] base, input logic [31:0] exp_buf);
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      step();
      check_val({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check_val({tag, "_data"}, 32'(data_out), 32'(base + 24'(i)));
      if (i == 0) begin
        check_val({tag, "_rdbuf"}, 32'(rd_buf), exp_buf);
        check_val({tag, "_frdy_clr"}, 32'(frame_rdy), 32'd0);
      end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    wr_en4 = 1'b0; rd_en4 = 1'b0; din4 = '0;
    step(); step();
    reset = 1'b0;
    check_val("rst_wr_rdy", 32'(wr_rdy), 32'd1);
    check_val("rst_wr_buf", 32'(wr_buf), 32'd0);
    check_val("rst_rd_buf", 32'(rd_buf), 32'd0);
    check_val("rst_frame_rdy", 32'(frame_rdy), 32'd0);
    check_val("rst_skip", 32'(frame_skip), 32'd0);
    check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_val("rst_data_out", 32'(data_out), 32'd0);

    // read strobe with nothing ever committed is ignored in every build
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check_val("nocommit_rd_valid", 32'(rd_valid), 32'd0);

    // 1: first frame into buf 0
    write_frame(24'h000001);
    check_val("t1_frame_rdy", 32'(frame_rdy), 32'd1);
    check_val("t1_wr_buf", 32'(wr_buf), 32'd1);
    check_val("t1_wr_rdy", 32'(wr_rdy), 32'd1);
    check_val("t1_skip", 32'(frame_skip), 32'd0);

    // 2: read it back
    read_frame("t2", 24'h000001, 32'd0);
    step();
    check_val("t2_idle_valid", 32'(rd_valid), 32'd0);
    check_val("t2_hold_data", 32'(data_out), 32'h000008);

    // 3: two unread frames then stall the writer behind a mid-frame scan
    write_frame(24'h000010);
    check_val("t3_wr_buf_a", 32'(wr_buf), 32'd0);
    write_frame(24'h000020);
    check_val("t3_skip", 32'(frame_skip), 32'd1);
    check_val("t3_wr_buf_b", 32'(wr_buf), 32'd1);
    step();
    check_val("t3_skip_clr", 32'(frame_skip), 32'd0);
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; step();
      check_val("t3_rd_data", 32'(data_out), 32'(24'h000020 + 24'(i)));
      if (i == 0) check_val("t3_rd_buf", 32'(rd_buf), 32'd0);
    end
    rd_en = 1'b0;
    write_frame(24'h000030);
    check_val("t3_wait_rdy", 32'(wr_rdy), 32'd0);
    check_val("t3_wait_buf", 32'(wr_buf), 32'd1);
    check_val("t3_wait_frdy", 32'(frame_rdy), 32'd1);
    wr_en = 1'b1; din = 24'h0000EE; step(); wr_en = 1'b0;
    check_val("t3_wait_hold", 32'(wr_rdy), 32'd0);
    for (int i = 3; i < 8; i++) begin
      rd_en = 1'b1; step();
      check_val("t3_rd_data", 32'(data_out), 32'(24'h000020 + 24'(i)));
      if (i < 7) check_val("t3_still_wait", 32'(wr_rdy), 32'd0);
    end
    rd_en = 1'b0;
    check_val("t3_release_rdy", 32'(wr_rdy), 32'd1);
    check_val("t3_release_buf", 32'(wr_buf), 32'd0);
    read_frame("t3b", 24'h000030, 32'd1);

    // 4: four-buffer instance, two commits with no reads
    for (int i = 0; i < 8; i++) begin
      wr_en4 = 1'b1; din4 = 24'h0000A0 + 24'(i); step();
    end
    wr_en4 = 1'b0;
    check_val("t4_a_frdy", 32'(frame_rdy4), 32'd1);
    check_val("t4_a_wr_buf", 32'(wr_buf4), 32'd1);
    check_val("t4_a_skip", 32'(frame_skip4), 32'd0);
    for (int i = 0; i < 8; i++) begin
      wr_en4 = 1'b1; din4 = 24'h0000B0 + 24'(i); step();
    end
    wr_en4 = 1'b0;
    check_val("t4_b_skip", 32'(frame_skip4), 32'd1);
    check_val("t4_b_wr_buf", 32'(wr_buf4), 32'd2);
    step();
    check_val("t4_skip_clr", 32'(frame_skip4), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_en4 = 1'b1; step();
      check_val("t4_valid", 32'(rd_valid4), 32'd1);
      check_val("t4_data", 32'(data_out4), 32'(24'h0000B0 + 24'(i)));
      if (i == 0) check_val("t4_rd_buf", 32'(rd_buf4), 32'd1);
    end
    rd_en4 = 1'b0;

    // 5: reset in the middle of a partial frame
    write_frame(24'h000060);
    check_val("t5_pre_wr_buf", 32'(wr_buf), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = 24'h000040 + 24'(i); step();
    end
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 24'h0000FF;
    step();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check_val("t5_wr_rdy", 32'(wr_rdy), 32'd1);
    check_val("t5_wr_buf", 32'(wr_buf), 32'd0);
    check_val("t5_frame_rdy", 32'(frame_rdy), 32'd0);
    check_val("t5_rd_valid", 32'(rd_valid), 32'd0);
    write_frame(24'h000050);
    check_val("t5_frdy", 32'(frame_rdy), 32'd1);
    read_frame("t5", 24'h000050, 32'd0);

    // 6: read strobe with frame_rdy low after a frame was committed and read
`ifdef FRAME_BUF_REPEAT_EN
    read_frame("t6", 24'h000050, 32'd0);
`else
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1; step();
      check_val("t6_no_valid", 32'(rd_valid), 32'd0);
      check_val("t6_hold_data", 32'(data_out), 32'h000057);
    end
    rd_en = 1'b0;
`endif
    check_val("t6_frame_rdy", 32'(frame_rdy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
